// File: rtl/dem_7seg_driver.sv
// dem_7seg_driver: binary countdown to two BCD digits (sequential double-dabble),
// driving a 2-digit multiplexed common-anode 7-segment display with tens blanking.
// Ports: clk, rst (async, active-low), dem[6:0] countdown, en display enable,
//        seg[6:0] {g..a} active-low, an[1:0] anodes active-low (an[0]=ones), busy.
module dem_7seg_driver #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] dem,
   input  logic       en,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       busy
);

   localparam int PW = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [6:0]    cap;
   logic [14:0]   sh;
   logic [14:0]   sh_adj;
   logic [2:0]    it;
   logic [3:0]    tens;
   logic [3:0]    ones;
   logic [PW-1:0] pre;
   logic          sel;
   logic [6:0]    dem_sat;
   logic [6:0]    seg_nxt;
   logic [1:0]    an_nxt;
   logic          busy_nxt;

   function automatic logic [6:0] enc(input logic [3:0] d);
      logic [6:0] s;
      s = 7'b1111111;
      case (d)
         4'd0: s = 7'b1000000;
         4'd1: s = 7'b1111001;
         4'd2: s = 7'b0100100;
         4'd3: s = 7'b0110000;
         4'd4: s = 7'b0011001;
         4'd5: s = 7'b0010010;
         4'd6: s = 7'b0000010;
         4'd7: s = 7'b1111000;
         4'd8: s = 7'b0000000;
         4'd9: s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   assign dem_sat = (dem > 7'd99) ? 7'd99 : dem;

   // add-3 correction on each BCD nibble before the shift
   always_comb begin
      sh_adj = sh;
      if (sh[14:11] >= 4'd5) sh_adj[14:11] = sh[14:11] + 4'd3;
      if (sh[10:7] >= 4'd5)  sh_adj[10:7]  = sh[10:7] + 4'd3;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (dem != cap) state_nxt = SHIFT;
         SHIFT:   if (it == 3'd6) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_nxt = (state_nxt != IDLE);
      an_nxt   = 2'b11;
      seg_nxt  = 7'b1111111;
      if (en) begin
         if (!sel) begin
            an_nxt  = 2'b10;
            seg_nxt = enc(ones);
         end else begin
            an_nxt  = 2'b01;
            seg_nxt = (tens == 4'd0) ? 7'b1111111 : enc(tens);
         end
      end
   end

   // cap keeps raw dem so any change re-triggers, even above 99
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap  <= '0;
         sh   <= '0;
         it   <= '0;
         tens <= '0;
         ones <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (dem != cap) begin
                  cap <= dem;
                  sh  <= {8'd0, dem_sat};
                  it  <= '0;
               end
            end
            SHIFT: begin
               sh <= {sh_adj[13:0], 1'b0};
               it <= it + 3'd1;
            end
            DONE: begin
               tens <= sh[14:11];
               ones <= sh[10:7];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre <= '0;
         sel <= 1'b0;
      end else if (pre == PW'(SCAN_DIV - 1)) begin
         pre <= '0;
         sel <= ~sel;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg  <= 7'b1111111;
         an   <= 2'b11;
         busy <= 1'b0;
      end else begin
         seg  <= seg_nxt;
         an   <= an_nxt;
         busy <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_dem_7seg_driver.sv
// tb_dem_7seg_driver: scoreboard bench for dem_7seg_driver, SCAN_DIV = 4.
// Stimulus pushes expected slot patterns; a monitor pops them on each busy fall.
module tb_dem_7seg_driver;

   localparam int SD = 4;

   typedef struct packed {
      logic [6:0] t;
      logic [6:0] o;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [6:0] dem;
   logic       en;
   logic [6:0] seg;
   logic [1:0] an;
   logic       busy;

   exp_t q[$];
   int   n_cmp;
   int   n_bad;
   int   done_cnt;
   int   exp_done;
   int   cyc;

   dem_7seg_driver #(.SCAN_DIV(SD)) dut (
      .clk  (clk),
      .rst  (rst),
      .dem  (dem),
      .en   (en),
      .seg  (seg),
      .an   (an),
      .busy (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // edges since reset release, used to predict the scan phase
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [6:0] t, input logic [6:0] o);
      exp_t e;
      e.t = t;
      e.o = o;
      q.push_back(e);
      exp_done++;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 120; i++) begin
         if (done_cnt >= exp_done) break;
         @(negedge clk);
      end
      if (done_cnt < exp_done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: done %0d want %0d", done_cnt, exp_done);
         done_cnt = exp_done;
      end
   endtask

   task automatic conv(input logic [6:0] v, input logic [6:0] t,
                       input logic [6:0] o);
      push(t, o);
      @(posedge clk);
      #1 dem = v;
      wait_done();
   endtask

   function automatic logic [1:0] phase_an();
      return ((((cyc - 1) / SD) % 2) == 1) ? 2'b01 : 2'b10;
   endfunction

   initial begin : monitor
      int         cnt;
      bit         hi;
      bit         gt;
      bit         go;
      exp_t       e;
      logic [6:0] st;
      logic [6:0] so;
      cnt = 0;
      hi  = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            cnt = 0;
            hi  = 0;
         end else if (busy) begin
            cnt++;
            hi = 1;
         end else if (hi) begin
            chk("busy_len", 8'(cnt), 8'd8);
            hi = 0;
            cnt = 0;
            gt = 0;
            go = 0;
            st = '1;
            so = '1;
            for (int i = 0; i < 2 * SD; i++) begin
               @(negedge clk);
               if (busy) begin
                  cnt++;
                  hi = 1;
               end
               if (an == 2'b01) begin
                  st = seg;
                  gt = 1;
               end
               if (an == 2'b10) begin
                  so = seg;
                  go = 1;
               end
            end
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_conv: got result, want none");
            end else begin
               e = q.pop_front();
               chk("tens_seg", {1'b0, st}, {1'b0, e.t});
               chk("ones_seg", {1'b0, so}, {1'b0, e.o});
               chk("slots", {6'd0, gt, go}, 8'd3);
            end
            done_cnt++;
         end
      end
   end

   initial begin : stim
      n_cmp = 0;
      n_bad = 0;
      done_cnt = 0;
      exp_done = 0;
      dem = 7'd0;
      en  = 1'b1;
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("rst_seg", {1'b0, seg}, 8'h7f);
      chk("rst_an", {6'd0, an}, 8'd3);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rel_an", {6'd0, an}, 8'b10);
      chk("rel_seg", {1'b0, seg}, 8'b01000000);
      for (int i = 0; i < 2 * SD; i++) begin
         @(negedge clk);
         chk("idle_busy", {7'd0, busy}, 8'd0);
         chk("scan_an", {6'd0, an}, {6'd0, phase_an()});
         if (an == 2'b01) chk("tens_blank", {1'b0, seg}, 8'h7f);
      end

      conv(7'd47, 7'b0011001, 7'b1111000);
      conv(7'd99, 7'b0010000, 7'b0010000);
      conv(7'd120, 7'b0010000, 7'b0010000);
      conv(7'd5, 7'b1111111, 7'b0010010);
      conv(7'd10, 7'b1111001, 7'b1000000);

      push(7'b0110000, 7'b1000000);
      push(7'b0100100, 7'b0010010);
      @(posedge clk);
      #1 dem = 7'd30;
      repeat (3) @(posedge clk);
      #1 dem = 7'd25;
      wait_done();

      conv(7'd12, 7'b1111001, 7'b0100100);
      @(posedge clk);
      #1 en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("dis_an", {6'd0, an}, 8'd3);
         chk("dis_seg", {1'b0, seg}, 8'h7f);
      end
      en = 1'b1;
      @(negedge clk);
      chk("en_an", {6'd0, an}, {6'd0, phase_an()});
      chk("en_seg", {1'b0, seg},
          (phase_an() == 2'b01) ? 8'b01111001 : 8'b00100100);

      push(7'b0000010, 7'b0110000);
      @(posedge clk);
      #1 dem = 7'd63;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_seg", {1'b0, seg}, 8'h7f);
      chk("mid_rst_an", {6'd0, an}, 8'd3);
      chk("mid_rst_busy", {7'd0, busy}, 8'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      wait_done();

      repeat (2) @(negedge clk);
      chk("queue_empty", 8'(q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
